// File: rtl/core_pkg.sv
// core_pkg: shared execute-stage types for the multi-cycle core.
//   exec_src_e  - execute source selector choices
//   muldiv_op_e - RV32M operation, encoded as the instruction funct3
// Helper functions decode signedness and divide class from muldiv_op_e.
package core_pkg;

  typedef enum logic [1:0] {
    EXEC_SRC_REG  = 2'd0,
    EXEC_SRC_IMM  = 2'd1,
    EXEC_SRC_PC   = 2'd2,
    EXEC_SRC_ZERO = 2'd3
  } exec_src_e;

  typedef enum logic [2:0] {
    MD_MUL    = 3'd0,
    MD_MULH   = 3'd1,
    MD_MULHSU = 3'd2,
    MD_MULHU  = 3'd3,
    MD_DIV    = 3'd4,
    MD_DIVU   = 3'd5,
    MD_REM    = 3'd6,
    MD_REMU   = 3'd7
  } muldiv_op_e;

  function automatic logic op_is_div(muldiv_op_e o);
    return o[2];
  endfunction

  // REM/REMU share bit 1 among the divide class
  function automatic logic op_is_rem(muldiv_op_e o);
    return o[2] & o[1];
  endfunction

  function automatic logic op_signed_a(muldiv_op_e o);
    return o inside {MD_MULH, MD_MULHSU, MD_DIV, MD_REM};
  endfunction

  function automatic logic op_signed_b(muldiv_op_e o);
    return o inside {MD_MULH, MD_DIV, MD_REM};
  endfunction

endpackage

// File: rtl/core_muldiv_step.sv
// core_muldiv_step: one combinational iteration of the shared datapath.
//   is_div   - 1: restoring-divide step, 0: shift-add multiply step
//   acc_hi   - upper accumulator half (product high / partial remainder)
//   acc_lo   - lower accumulator half (multiplier bits / dividend-quotient)
//   operand  - multiplicand or divisor magnitude
//   next_hi, next_lo - accumulator after this iteration
module core_muldiv_step (
  input  logic        is_div,
  input  logic [31:0] acc_hi,
  input  logic [31:0] acc_lo,
  input  logic [31:0] operand,
  output logic [31:0] next_hi,
  output logic [31:0] next_lo
);

  logic [32:0] sum;
  logic [32:0] rem_sh;
  logic [32:0] diff;

  always_comb begin
    sum    = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, operand} : '0);
    rem_sh = {acc_hi, acc_lo[31]};
    // rem_sh < 2*divisor, so bit 32 of the 33-bit difference is the borrow
    diff   = rem_sh - {1'b0, operand};
    if (is_div) begin
      if (!diff[32]) begin
        next_hi = diff[31:0];
        next_lo = {acc_lo[30:0], 1'b1};
      end else begin
        next_hi = rem_sh[31:0];
        next_lo = {acc_lo[30:0], 1'b0};
      end
    end else begin
      next_hi = sum[32:1];
      next_lo = {sum[0], acc_lo[31:1]};
    end
  end

endmodule

// File: rtl/core_exec_muldiv.sv
// core_exec_muldiv: iterative RV32M multiply/divide unit (execute stage).
//   clk, rst      - clock, synchronous active-high reset
//   start, op     - request strobe and operation, taken only when ready
//   src_a, src_b  - rs1 / rs2 operands, registered at accept
//   flush         - abort the in-flight operation, result left unchanged
//   ready, busy   - idle / operation in flight (decoded from state)
//   done          - one-cycle pulse when result is valid
//   result        - final value, held until overwritten by a later op
// Normal ops: 32 CALC cycles + FIXUP, done at T+34. Divide-by-zero and
// signed overflow resolve at accept, done at T+1.
module core_exec_muldiv
  import core_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  muldiv_op_e  op,
  input  logic [31:0] src_a,
  input  logic [31:0] src_b,
  input  logic        flush,
  output logic        ready,
  output logic        busy,
  output logic        done,
  output logic [31:0] result
);

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIXUP, S_DONE} state_e;

  state_e      state_q, state_d;
  muldiv_op_e  op_q;
  logic [31:0] acc_hi_q, acc_lo_q, operand_q, result_q;
  logic [31:0] step_hi, step_lo;
  logic [4:0]  cnt_q;
  logic        neg_q, neg_rem_q;

  logic        sgn_a, sgn_b, div_zero, div_ovf, special, accept;
  logic [31:0] mag_a, mag_b, special_res, fix_res;
  logic [63:0] prod;

  always_comb begin
    sgn_a    = op_signed_a(op) & src_a[31];
    sgn_b    = op_signed_b(op) & src_b[31];
    mag_a    = sgn_a ? -src_a : src_a;
    mag_b    = sgn_b ? -src_b : src_b;
    div_zero = op_is_div(op) && (src_b == '0);
    div_ovf  = (op == MD_DIV || op == MD_REM) &&
               (src_a == 32'h8000_0000) && (src_b == '1);
    special  = div_zero | div_ovf;
    if (div_zero)
      special_res = op_is_rem(op) ? src_a : '1;
    else
      special_res = op_is_rem(op) ? '0 : 32'h8000_0000;
    accept = (state_q == S_IDLE) && start && !flush;
  end

  always_comb begin
    state_d = state_q;
    if (flush) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE:  if (start) state_d = special ? S_DONE : S_CALC;
        S_CALC:  if (cnt_q == 5'd31) state_d = S_FIXUP;
        S_FIXUP: state_d = S_DONE;
        S_DONE:  state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  core_muldiv_step u_step (
    .is_div  (op_is_div(op_q)),
    .acc_hi  (acc_hi_q),
    .acc_lo  (acc_lo_q),
    .operand (operand_q),
    .next_hi (step_hi),
    .next_lo (step_lo)
  );

  // neg_q: product sign for multiply, quotient sign for divide
  always_comb begin
    prod = {acc_hi_q, acc_lo_q};
    if (neg_q) prod = -prod;
    case (op_q)
      MD_MUL:                     fix_res = prod[31:0];
      MD_MULH, MD_MULHSU, MD_MULHU: fix_res = prod[63:32];
      MD_DIV, MD_DIVU:            fix_res = neg_q ? -acc_lo_q : acc_lo_q;
      default:                    fix_res = neg_rem_q ? -acc_hi_q : acc_hi_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      op_q      <= MD_MUL;
      acc_hi_q  <= '0;
      acc_lo_q  <= '0;
      operand_q <= '0;
      cnt_q     <= '0;
      neg_q     <= 1'b0;
      neg_rem_q <= 1'b0;
      result_q  <= '0;
    end else if (accept) begin
      op_q      <= op;
      acc_hi_q  <= '0;
      acc_lo_q  <= op_is_div(op) ? mag_a : mag_b;
      operand_q <= op_is_div(op) ? mag_b : mag_a;
      cnt_q     <= '0;
      neg_q     <= sgn_a ^ sgn_b;
      neg_rem_q <= sgn_a;
      if (special) result_q <= special_res;
    end else if (!flush) begin
      if (state_q == S_CALC) begin
        acc_hi_q <= step_hi;
        acc_lo_q <= step_lo;
        cnt_q    <= cnt_q + 5'd1;
      end
      if (state_q == S_FIXUP) result_q <= fix_res;
    end
  end

  assign ready  = (state_q == S_IDLE);
  assign busy   = (state_q != S_IDLE);
  assign done   = (state_q == S_DONE);
  assign result = result_q;

endmodule

// File: tb/tb_core_exec_muldiv.sv
module tb_core_exec_muldiv;
  import core_pkg::*;

  logic        clk = 1'b0;
  logic        rst, start, flush;
  muldiv_op_e  op;
  logic [31:0] src_a, src_b;
  logic        ready, busy, done;
  logic [31:0] result;

  int          vectors = 0;
  int          miscompares = 0;
  logic [31:0] exp_q[$];
  logic [31:0] held = '0;

  always #5 clk = ~clk;

  core_exec_muldiv dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .op     (op),
    .src_a  (src_a),
    .src_b  (src_b),
    .flush  (flush),
    .ready  (ready),
    .busy   (busy),
    .done   (done),
    .result (result)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    vectors++;
    assert (obs === expv) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  function automatic logic [31:0] model(muldiv_op_e o, logic [31:0] a, logic [31:0] b);
    logic [63:0] as64, bs64, au64, bu64, p;
    logic signed [31:0] sa, sb, r;
    as64 = {{32{a[31]}}, a};
    bs64 = {{32{b[31]}}, b};
    au64 = {32'b0, a};
    bu64 = {32'b0, b};
    sa = a;
    sb = b;
    case (o)
      MD_MUL:    begin p = au64 * bu64; return p[31:0];  end
      MD_MULH:   begin p = as64 * bs64; return p[63:32]; end
      MD_MULHSU: begin p = as64 * bu64; return p[63:32]; end
      MD_MULHU:  begin p = au64 * bu64; return p[63:32]; end
      MD_DIV: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
        r = sa / sb; return r;
      end
      MD_DIVU: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      MD_REM: begin
        if (b == 0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
        r = sa % sb; return r;
      end
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  function automatic int model_lat(muldiv_op_e o, logic [31:0] a, logic [31:0] b);
    if (o inside {MD_DIV, MD_DIVU, MD_REM, MD_REMU} && b == 0) return 1;
    if (o inside {MD_DIV, MD_REM} && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
    return 34;
  endfunction

  task automatic accept(input muldiv_op_e o, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    start = 1'b1; op = o; src_a = a; src_b = b;
    @(posedge clk);
    #1;
    start = 1'b0; op = MD_MULHU; src_a = $urandom; src_b = $urandom;
  endtask

  // poke_k > 0: pulse a competing start in cycle T+poke_k
  task automatic wait_result(input string tag, input int lat, input int poke_k);
    logic [31:0] e;
    bit seen;
    seen = 0;
    for (int k = 1; k <= 60 && !seen; k++) begin
      @(negedge clk);
      if (poke_k > 0) begin
        start = (k == poke_k);
        if (k == poke_k) begin op = MD_DIVU; src_a = 32'd100; src_b = 32'd7; end
      end
      if (done === 1'b1) begin
        seen = 1;
        check({tag, "_lat"}, 32'(k), 32'(lat));
        e = exp_q.pop_front();
        check(tag, result, e);
        held = e;
      end
    end
    start = 1'b0;
    if (!seen) begin
      check({tag, "_timeout"}, {31'b0, done}, 32'd1);
      void'(exp_q.pop_front());
    end
  endtask

  task automatic run(input string tag, input muldiv_op_e o, input logic [31:0] a,
                     input logic [31:0] b, input logic [31:0] e, input int lat);
    exp_q.push_back(e);
    accept(o, a, b);
    wait_result(tag, lat, 0);
  endtask

  initial begin
    muldiv_op_e ro;
    logic [31:0] ra, rb;

    rst = 1'b1; start = 1'b0; flush = 1'b0; op = MD_MUL; src_a = '0; src_b = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_ready",  {31'b0, ready}, 32'd1);
    check("rst_busy",   {31'b0, busy},  32'd0);
    check("rst_done",   {31'b0, done},  32'd0);
    check("rst_result", result,         32'd0);

    run("mul_7x6",      MD_MUL,    32'd7,          32'd6,          32'd42,         34);
    @(negedge clk);
    check("done_pulse", {31'b0, done},  32'd0);
    check("ready_after",{31'b0, ready}, 32'd1);
    run("mulhu_max",    MD_MULHU,  32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'hFFFF_FFFE,  34);
    run("mulh_m1x2",    MD_MULH,   32'hFFFF_FFFF,  32'd2,          32'hFFFF_FFFF,  34);
    run("mulhsu_m1",    MD_MULHSU, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'hFFFF_FFFF,  34);
    run("div_m7_2",     MD_DIV,    32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFD,  34);
    run("rem_m7_2",     MD_REM,    32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFF,  34);
    run("divu_100_7",   MD_DIVU,   32'd100,        32'd7,          32'd14,         34);
    run("remu_100_7",   MD_REMU,   32'd100,        32'd7,          32'd2,          34);
    run("divu_by0",     MD_DIVU,   32'd5,          32'd0,          32'hFFFF_FFFF,  1);
    run("rem_by0",      MD_REM,    32'd5,          32'd0,          32'd5,          1);
    run("div_ovf",      MD_DIV,    32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  1);
    run("rem_ovf",      MD_REM,    32'h8000_0000,  32'hFFFF_FFFF,  32'd0,          1);

    for (int i = 0; i < 12; i++) begin
      ro = muldiv_op_e'(3'($urandom_range(0, 7)));
      ra = $urandom;
      rb = (i % 5 == 0) ? 32'd0 : $urandom;
      run("rand", ro, ra, rb, model(ro, ra, rb), model_lat(ro, ra, rb));
    end

    // flush at T+10: no done, idle at T+11, result untouched
    accept(MD_MUL, 32'd3, 32'd3);
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      check("flush_nodone", {31'b0, done}, 32'd0);
    end
    flush = 1'b1;
    @(posedge clk);
    #1 flush = 1'b0;
    @(negedge clk);
    check("flush_ready",  {31'b0, ready}, 32'd1);
    check("flush_busy",   {31'b0, busy},  32'd0);
    check("flush_done",   {31'b0, done},  32'd0);
    check("flush_result", result,         held);
    run("mul_2x5", MD_MUL, 32'd2, 32'd5, 32'd10, 34);

    // start and flush together in IDLE: request dropped
    @(negedge clk);
    start = 1'b1; flush = 1'b1; op = MD_MUL; src_a = 32'd9; src_b = 32'd9;
    @(posedge clk);
    #1 start = 1'b0; flush = 1'b0;
    @(negedge clk);
    check("sf_ready", {31'b0, ready}, 32'd1);
    check("sf_busy",  {31'b0, busy},  32'd0);

    // start during CALC ignored; result held afterwards
    exp_q.push_back(32'd42);
    accept(MD_MUL, 32'd7, 32'd6);
    wait_result("mul_poked", 34, 5);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check("hold_done",   {31'b0, done}, 32'd0);
      check("hold_result", result,        held);
    end

    // reset at T+20
    accept(MD_DIVU, 32'd1000, 32'd3);
    repeat (19) @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("mrst_ready",  {31'b0, ready}, 32'd1);
    check("mrst_busy",   {31'b0, busy},  32'd0);
    check("mrst_done",   {31'b0, done},  32'd0);
    check("mrst_result", result,         32'd0);
    run("divu_post", MD_DIVU, 32'd1000, 32'd3, 32'd333, 34);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
